// File: rtl/time_entry_ctrl_if.sv
// Keypad-to-time-load bus: key decoder inputs plus the buffered digits,
// load strobes and status driven by the time-entry controller.
interface time_entry_ctrl_if;
    logic [3:0] key;
    logic       key_valid;
    logic [3:0] key_ms_hr;
    logic [3:0] key_ls_hr;
    logic [3:0] key_ms_min;
    logic [3:0] key_ls_min;
    logic       load_new_c;
    logic       load_new_a;
    logic       show_new_time;
    logic       entry_error;

    // Controller side: consumes keys, drives digits and strobes.
    modport master (
        input  key, key_valid,
        output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
        output load_new_c, load_new_a, show_new_time, entry_error
    );

    // Environment side: supplies keys, consumes digits and strobes.
    modport slave (
        output key, key_valid,
        input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
        input  load_new_c, load_new_a, show_new_time, entry_error
    );
endinterface

// File: rtl/time_entry_ctrl.sv
// Keypad time-entry controller: shifts digits into an HH:MM buffer,
// range-checks on TIME/ALARM and issues a one-cycle load strobe.
module time_entry_ctrl #(
    parameter int TIMEOUT_SECS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              one_second,
    time_entry_ctrl_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_SECS + 1);
    localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT_SECS);

    localparam logic [3:0] KEY_TIME  = 4'hA;
    localparam logic [3:0] KEY_ALARM = 4'hB;

    typedef enum logic [0:0] {IDLE = 1'b0, ENTRY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    ms_hr_q, ms_hr_d;
    logic [3:0]    ls_hr_q, ls_hr_d;
    logic [3:0]    ms_min_q, ms_min_d;
    logic [3:0]    ls_min_q, ls_min_d;
    logic          load_c_q, load_c_d;
    logic          load_a_q, load_a_d;
    logic          err_q, err_d;
    logic          show_q, show_d;

    logic          is_digit_s;
    logic          time_ok_s;

    // A buffered time is legal when it lies in 00:00..23:59.
    function automatic logic time_ok(input logic [3:0] mh, input logic [3:0] lh,
                                     input logic [3:0] mm);
        return (mh <= 4'd2) && ((mh < 4'd2) || (lh <= 4'd3)) && (mm <= 4'd5);
    endfunction

    assign is_digit_s = (bus.key <= 4'd9);
    assign time_ok_s  = time_ok(ms_hr_q, ls_hr_q, ms_min_q);

    // Next-state, buffer, timer and strobe decode.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ms_hr_d  = ms_hr_q;
        ls_hr_d  = ls_hr_q;
        ms_min_d = ms_min_q;
        ls_min_d = ls_min_q;
        load_c_d = 1'b0;
        load_a_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.key_valid && is_digit_s) begin
                    ms_hr_d  = 4'd0;
                    ls_hr_d  = 4'd0;
                    ms_min_d = 4'd0;
                    ls_min_d = bus.key;
                    timer_d  = '0;
                    state_d  = ENTRY;
                end else begin
                    state_d = IDLE;
                end
            end
            ENTRY: begin
                if (bus.key_valid) begin
                    if (is_digit_s) begin
                        ms_hr_d  = ls_hr_q;
                        ls_hr_d  = ms_min_q;
                        ms_min_d = ls_min_q;
                        ls_min_d = bus.key;
                        timer_d  = '0;
                    end else if ((bus.key == KEY_TIME) || (bus.key == KEY_ALARM)) begin
                        // Buffer is kept so the consumer sees digits with the strobe.
                        if (time_ok_s) begin
                            load_c_d = (bus.key == KEY_TIME);
                            load_a_d = (bus.key == KEY_ALARM);
                        end else begin
                            err_d = 1'b1;
                        end
                        timer_d = '0;
                        state_d = IDLE;
                    end else begin
                        // Codes C..F: ignored, timer keeps running.
                        state_d = ENTRY;
                    end
                end else if (one_second) begin
                    if ((timer_q + TW'(1)) == TIMEOUT_W) begin
                        ms_hr_d  = 4'd0;
                        ls_hr_d  = 4'd0;
                        ms_min_d = 4'd0;
                        ls_min_d = 4'd0;
                        timer_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    state_d = ENTRY;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        show_d = (state_d == ENTRY);
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            ms_hr_q  <= 4'd0;
            ls_hr_q  <= 4'd0;
            ms_min_q <= 4'd0;
            ls_min_q <= 4'd0;
            load_c_q <= 1'b0;
            load_a_q <= 1'b0;
            err_q    <= 1'b0;
            show_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ms_hr_q  <= ms_hr_d;
            ls_hr_q  <= ls_hr_d;
            ms_min_q <= ms_min_d;
            ls_min_q <= ls_min_d;
            load_c_q <= load_c_d;
            load_a_q <= load_a_d;
            err_q    <= err_d;
            show_q   <= show_d;
        end
    end

    assign bus.key_ms_hr     = ms_hr_q;
    assign bus.key_ls_hr     = ls_hr_q;
    assign bus.key_ms_min    = ms_min_q;
    assign bus.key_ls_min    = ls_min_q;
    assign bus.load_new_c    = load_c_q;
    assign bus.load_new_a    = load_a_q;
    assign bus.show_new_time = show_q;
    assign bus.entry_error   = err_q;
endmodule

// File: doc/time_entry_ctrl.md
# time_entry_ctrl

Keypad time-entry controller for the alarm clock. Collects decimal digits from the key decoder into a four-digit HH:MM shift buffer and range-checks the entered time. On a TIME or ALARM command it issues a one-cycle load strobe, together with the buffered digits, to the current-time counter or the alarm register. It is the writer side of the counter's load-new-time interface.

## Interface

Parameters:
- TIMEOUT_SECS, 10, number of one_second ticks without a key press before an entry is abandoned (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- one_second  in  1  one-cycle tick, once per second
- key  in  4  key code: 0–9 digit, 4'hA TIME command, 4'hB ALARM command, 4'hC–4'hF ignored
- key_valid  in  1  one-cycle strobe per key press; key is sampled only when high
- key_ms_hr  out  4  buffered hour tens digit (BCD)
- key_ls_hr  out  4  buffered hour units digit (BCD)
- key_ms_min  out  4  buffered minute tens digit (BCD)
- key_ls_min  out  4  buffered minute units digit (BCD)
- load_new_c  out  1  one-cycle strobe: load key_* digits as the current time
- load_new_a  out  1  one-cycle strobe: load key_* digits as the alarm time
- show_new_time  out  1  high while an entry is in progress; display mux selects key_*
- entry_error  out  1  one-cycle strobe: a command was rejected as out of range

## Operation

- All outputs are registered. Reset value of every output is 0, state is IDLE, and the timer is 0.
- States: IDLE and ENTRY.
- IDLE:
  - A digit key clears the buffer, writes the digit to key_ls_min, clears the timer, and moves to ENTRY.
  - TIME, ALARM and ignored codes have no effect.
- ENTRY, digit key:
  - Shift left: ms_hr←ls_hr, ls_hr←ms_min, ms_min←ls_min, ls_min←key.
  - Clear the timer.
  - After more than four digits, the oldest digit is dropped.
- ENTRY, TIME or ALARM key: validate the buffer.
  - The buffer is valid iff ms_hr≤2, (ms_hr<2 or ls_hr≤3), and ms_min≤5.
  - Valid: pulse load_new_c (TIME) or load_new_a (ALARM).
  - Invalid: pulse entry_error and assert no load strobe.
  - Either way, return to IDLE.
- ENTRY, codes 4'hC–4'hF: ignored; the timer is not cleared.
- ENTRY, one_second without key_valid: timer+1. When the incremented value equals TIMEOUT_SECS, return to IDLE and clear the buffer; no strobe is issued.
- The timer is $clog2(TIMEOUT_SECS+1) bits wide and never wraps.
- Fewer than four digits entered: the upper digits remain 0 (leading zeros). For example, "7" then TIME loads 00:07.
- After a load, the buffer holds its value in IDLE until the next digit arrives.
- load_new_c, load_new_a and entry_error are mutually exclusive and never assert in IDLE-to-IDLE cycles.

## Timing

- Key to buffer: a digit sampled at edge N appears on key_* after edge N. show_new_time rises after the same edge when leaving IDLE.
- Command to strobe: a TIME/ALARM sampled at edge N asserts its strobe for exactly the cycle after edge N.
  - show_new_time falls at the same edge.
  - key_* are stable throughout the strobe cycle, so the consumer samples the digits and the strobe together.
- Timeout: the edge that samples the TIMEOUT_SECS-th consecutive tick moves the block to IDLE. key_* read 0 and show_new_time reads 0 in the following cycle.
- Simultaneous key_valid and one_second: the key is processed and the timer is cleared. No timeout can occur in that cycle.
- Back-to-back key_valid on consecutive cycles: each key is processed in order.
  - A command followed immediately by a digit starts a new entry in the next cycle.
- Reset mid-entry: immediate return to IDLE, all outputs 0, no strobe, including a strobe that would have been due in the next cycle.

## Test plan

- Reset, then keys 1,2,3,4,TIME → key_*=1,2,3,4; load_new_c=1 for exactly one cycle with the digits stable; show_new_time 1 during entry, then 0.
- Keys 2,4,0,0,TIME → entry_error one cycle, no load_new_c; keys 0,6,3,0,ALARM → load_new_a one cycle, key_*=0,6,3,0.
- Keys 9,1,2,3,5,9,TIME → buffer 23:59 (oldest digits dropped), load_new_c pulses; then key 7, TIME → buffer 00:07, load_new_c.
- TIMEOUT_SECS=10: key 5, then 9 ticks → still ENTRY; 10th tick → IDLE, key_*=0, no strobes. Key_valid coincident with the 10th tick → entry continues and the timer clears.
- Key 4'hE in ENTRY → buffer unchanged and the timer is not cleared. TIME in IDLE → no strobe.
- Assert reset in the cycle a TIME key is sampled after 1,2,3,4 → no load_new_c, all outputs 0, state IDLE.
